// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types for the ALU writeback stage.
//   REG_WIDTH_DEFAULT / NREGS_DEFAULT : default datapath width and register count
//   wb_entry_t  : one buffered ALU result {data, rd, we, setflags, c, v}
//   flags_t     : architectural flag register {c, v, z, n}
//   wb_state_e  : buffer occupancy FSM {EMPTY, ONE, FULL}
// The entry struct is sized from the package defaults, so the REG_WIDTH and
// NREGS parameters of alu_writeback must stay at these values.
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int REG_WIDTH_DEFAULT = 16;
  localparam int NREGS_DEFAULT     = 8;
  localparam int ADDR_W_DEFAULT    = $clog2(NREGS_DEFAULT);

  typedef struct packed {
    logic [REG_WIDTH_DEFAULT-1:0] data;
    logic [ADDR_W_DEFAULT-1:0]    rd;
    logic                         we;
    logic                         setflags;
    logic                         c;
    logic                         v;
  } wb_entry_t;

  typedef struct packed {
    logic c;
    logic v;
    logic z;
    logic n;
  } flags_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } wb_state_e;

endpackage

// File: rtl/alu_wb_fifo.sv
// -----------------------------------------------------------------------------
// alu_wb_fifo
// Two-entry in-order buffer for the writeback stage with its occupancy FSM.
//   clk, rst   : clock, asynchronous active-high reset (state only)
//   push       : write push_entry at the tail (ignored when FULL)
//   push_entry : entry to buffer
//   pop        : drop the head (ignored when EMPTY)
//   state      : occupancy EMPTY / ONE / FULL
//   head       : oldest buffered entry (valid when state != EMPTY)
//   youngest   : most recently buffered entry (valid when state != EMPTY)
// -----------------------------------------------------------------------------
module alu_wb_fifo
  import alu_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output wb_state_e state,
  output wb_entry_t head,
  output wb_entry_t youngest
);

  wb_state_e state_q, state_d;
  logic      rd_ptr_q, rd_ptr_d;
  logic      push_ok, pop_ok, wr_idx;
  wb_entry_t mem_q [2];

  always_comb begin
    push_ok  = push && (state_q != FULL);
    pop_ok   = pop && (state_q != EMPTY);
    rd_ptr_d = rd_ptr_q ^ pop_ok;
    // Tail slot: the head slot itself when empty, otherwise the other slot.
    wr_idx   = (state_q == EMPTY) ? rd_ptr_q : ~rd_ptr_q;
    state_d  = state_q;
    case (state_q)
      EMPTY: if (push_ok) state_d = ONE;
      ONE: begin
        if (push_ok && !pop_ok)      state_d = FULL;
        else if (!push_ok && pop_ok) state_d = EMPTY;
      end
      FULL:    if (pop_ok) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= EMPTY;
      rd_ptr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Payload storage carries no reset; occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_idx] <= push_entry;
  end

  assign state    = state_q;
  assign head     = mem_q[rd_ptr_q];
  assign youngest = (state_q == FULL) ? mem_q[~rd_ptr_q] : mem_q[rd_ptr_q];

endmodule

// File: rtl/alu_writeback.sv
// -----------------------------------------------------------------------------
// alu_writeback
// Writeback stage behind the ALU: buffers up to two results, retires them in
// order into the register-file write port and owns the C/V/Z/N flag register.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid/in_ready    : ALU result handshake (in_ready depends on state only)
//   in_data, in_rd, in_we, in_setflags, in_flagc, in_flagv : ALU result fields
//   wb_stall             : register-file port busy, hold the head entry
//   rf_we/rf_waddr/rf_wdata : register-file write port
//   flagc_q..flagn_q     : flag register; flagc_q feeds the ALU carry-in
//   pending              : buffer non-empty
// Optional macro ALU_WB_FWD_EN adds fwd_valid/fwd_addr/fwd_data describing the
// youngest buffered entry that will write a register.
// -----------------------------------------------------------------------------
module alu_writeback
  import alu_pkg::*;
#(
  parameter int REG_WIDTH = REG_WIDTH_DEFAULT,
  parameter int NREGS     = NREGS_DEFAULT,
  localparam int ADDR_W   = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [REG_WIDTH-1:0] in_data,
  input  logic [ADDR_W-1:0]    in_rd,
  input  logic                 in_we,
  input  logic                 in_setflags,
  input  logic                 in_flagc,
  input  logic                 in_flagv,
  input  logic                 wb_stall,
  output logic                 rf_we,
  output logic [ADDR_W-1:0]    rf_waddr,
  output logic [REG_WIDTH-1:0] rf_wdata,
  output logic                 flagc_q,
  output logic                 flagv_q,
  output logic                 flagz_q,
  output logic                 flagn_q,
  output logic                 pending
`ifdef ALU_WB_FWD_EN
  ,
  output logic                 fwd_valid,
  output logic [ADDR_W-1:0]    fwd_addr,
  output logic [REG_WIDTH-1:0] fwd_data
`endif
);

  wb_state_e state;
  wb_entry_t head, youngest, push_entry;
  flags_t    flags_q, flags_d;
  logic      retire;

  always_comb begin
    push_entry          = '0;
    push_entry.data     = in_data;
    push_entry.rd       = in_rd;
    push_entry.we       = in_we;
    push_entry.setflags = in_setflags;
    push_entry.c        = in_flagc;
    push_entry.v        = in_flagv;
  end

  alu_wb_fifo u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (in_valid),
    .push_entry (push_entry),
    .pop        (retire),
    .state      (state),
    .head       (head),
    .youngest   (youngest)
  );

  assign in_ready = (state != FULL);
  assign pending  = (state != EMPTY);
  assign retire   = pending && !wb_stall;
  assign rf_we    = retire && head.we;
  assign rf_waddr = head.rd;
  assign rf_wdata = head.data;

  always_comb begin
    flags_d = flags_q;
    if (retire && head.setflags) begin
      flags_d.c = head.c;
      flags_d.v = head.v;
      flags_d.z = (head.data == '0);
      flags_d.n = head.data[REG_WIDTH-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) flags_q <= '0;
    else     flags_q <= flags_d;
  end

  assign flagc_q = flags_q.c;
  assign flagv_q = flags_q.v;
  assign flagz_q = flags_q.z;
  assign flagn_q = flags_q.n;

`ifdef ALU_WB_FWD_EN
  // Prefer the youngest entry; when it is a compare, fall back to the head.
  always_comb begin
    fwd_valid = 1'b0;
    fwd_addr  = youngest.rd;
    fwd_data  = youngest.data;
    if ((state != EMPTY) && youngest.we) begin
      fwd_valid = 1'b1;
    end else if ((state == FULL) && head.we) begin
      fwd_valid = 1'b1;
      fwd_addr  = head.rd;
      fwd_data  = head.data;
    end
  end
`else
  logic unused_youngest;
  assign unused_youngest = ^youngest;
`endif

endmodule
